digmod_share_arb: RTL

- Shares one fixed-latency digit modular-reduction pipeline (21-bit in, 18-bit out) between N_REQ requesters.
- Round-robin arbitration issues at most one operand per cycle into the pipeline.
- A tag shift register tracks requester ID alongside each operand, and results return in issue order through a credit-protected result FIFO with valid/ready backpressure.
- Sits between the RNS digit lanes and a single reduction pipeline instance.

---
 rtl/digmod_share_arb.sv | 138 +++++++++++++
 1 files changed

// File: rtl/digmod_share_arb.sv
// rtl/digmod_share_arb.sv - round-robin sharing of one fixed-latency digit reduction pipeline
// Results return in issue order through a credit-protected FIFO tagged with the requester ID.
module digmod_share_arb #(
    parameter int N_REQ      = 4,
    parameter int ID_WIDTH   = 2,
    parameter int IN_WIDTH   = 21,
    parameter int DATA_WIDTH = 18,
    parameter int PIPE_LAT   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*IN_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [IN_WIDTH-1:0]       pipe_in_,
    input  logic [DATA_WIDTH-1:0]     pipe_out_,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [DATA_WIDTH-1:0]     res_data,
    output logic [ID_WIDTH-1:0]       res_id,
    output logic                      busy
);
    localparam int CW = $clog2(FIFO_DEPTH + PIPE_LAT + 1) + 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [PIPE_LAT-1:0]   tag_vld;
    logic [ID_WIDTH-1:0]   tag_id [PIPE_LAT];
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         fifo_count;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [ID_WIDTH-1:0]   mem_id [FIFO_DEPTH];

    logic                can_issue;
    logic                grant_any;
    logic [ID_WIDTH-1:0] grant_idx;
    logic                push;
    logic                pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Every issued operand reserves a FIFO slot until it is popped, so the FIFO never overflows.
    assign can_issue = (inflight + fifo_count) < CW'(FIFO_DEPTH);
    assign push      = tag_vld[PIPE_LAT-1];
    assign res_valid = (fifo_count != '0);
    assign pop       = res_valid & res_ready;
    assign res_data  = res_valid ? mem_data[rd_ptr] : '0;
    assign res_id    = res_valid ? mem_id[rd_ptr] : '0;
    assign busy      = (inflight != '0) || res_valid;

    always_comb begin
        int                  j;
        logic [ID_WIDTH-1:0] jj;
        grant_any = 1'b0;
        grant_idx = '0;
        j         = 0;
        jj        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            jj = ID_WIDTH'(j);
            if (!grant_any && req_valid[jj] && can_issue && !reset) begin
                grant_any = 1'b1;
                grant_idx = jj;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        pipe_in_  = '0;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
            pipe_in_             = req_data[int'(grant_idx)*IN_WIDTH +: IN_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr   <= ID_WIDTH'(N_REQ - 1);
            tag_vld  <= '0;
            inflight <= '0;
            for (int s = 0; s < PIPE_LAT; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            if (grant_any) begin
                rr_ptr <= grant_idx;
            end
            tag_vld[0] <= grant_any;
            tag_id[0]  <= grant_idx;
            for (int s = 1; s < PIPE_LAT; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
            case ({grant_any, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: push is held low while reset is asserted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= pipe_out_;
            mem_id[wr_ptr]   <= tag_id[PIPE_LAT-1];
        end
    end
endmodule
